// File: rtl/lap_stopwatch.sv
// lap_stopwatch: stopwatch core with run/pause toggle, lap capture, clear and saturating up-count.
// Define LAP_STOPWATCH_COUNTDOWN_EN to add countdown mode (preset load, borrow chain, EXPIRED state).
// state   | meaning
// IDLE    | cleared, waiting for start
// RUN     | counting, live time displayed
// LAP     | counting underneath, display frozen on the latched split
// STOP    | paused (also entered on up-count saturation)
// EXPIRED | countdown reached 0:00.00 (countdown build only)
module lap_stopwatch #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int MAX_MINUTES = 99,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_start_stop,
    input  logic                       btn_lap,
    input  logic                       btn_clear,
    input  logic                       mode_down,
    input  logic [6:0]                 preset_min,
    input  logic [5:0]                 preset_sec,
    output logic [6:0]                 minutes,
    output logic [5:0]                 seconds,
    output logic [$clog2(TICK_HZ)-1:0] fraction,
    output logic                       running,
    output logic                       lap_active,
    output logic                       overflow,
    output logic                       expired
);

    localparam int FW  = $clog2(TICK_HZ);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [FW-1:0] FRAC_TOP = FW'(TICK_HZ - 1);
    localparam logic [6:0]    MIN_TOP  = 7'(MAX_MINUTES);
    localparam logic [PW-1:0] PRE_TOP  = PW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        LAP  = 3'd2,
        STOP = 3'd3
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
        , EXPIRED = 3'd4
`endif
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_ss, sync_lap, sync_clr;
    logic                   prev_ss, prev_lap, prev_clr;
    logic                   pulse_ss, pulse_lap, pulse_clr;

    logic [PW-1:0] presc;
    logic [6:0]    min_q, lap_min_q, inc_min, dec_min;
    logic [5:0]    sec_q, lap_sec_q, inc_sec, dec_sec;
    logic [FW-1:0] frac_q, lap_frac_q, inc_frac, dec_frac;
    logic          ovf_q;
    logic          counting, tick, at_max, time_zero, sat, down_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ss  <= '0;
            sync_lap <= '0;
            sync_clr <= '0;
            prev_ss  <= 1'b0;
            prev_lap <= 1'b0;
            prev_clr <= 1'b0;
        end else begin
            sync_ss  <= {sync_ss[SYNC_STAGES-2:0], btn_start_stop};
            sync_lap <= {sync_lap[SYNC_STAGES-2:0], btn_lap};
            sync_clr <= {sync_clr[SYNC_STAGES-2:0], btn_clear};
            prev_ss  <= sync_ss[SYNC_STAGES-1];
            prev_lap <= sync_lap[SYNC_STAGES-1];
            prev_clr <= sync_clr[SYNC_STAGES-1];
        end
    end

    assign pulse_ss  = sync_ss[SYNC_STAGES-1] & ~prev_ss;
    assign pulse_lap = sync_lap[SYNC_STAGES-1] & ~prev_lap;
    assign pulse_clr = sync_clr[SYNC_STAGES-1] & ~prev_clr;

    assign counting  = (state == RUN) || (state == LAP);
    assign tick      = counting && (presc == PRE_TOP);
    assign at_max    = (min_q == MIN_TOP) && (sec_q == 6'd59) && (frac_q == FRAC_TOP);
    assign time_zero = (min_q == 7'd0) && (sec_q == 6'd0) && (frac_q == '0);
    // Saturation is the tick that would step past the top value; the lost step flags overflow.
    assign sat       = tick && !down_q && at_max;

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
    logic       expire_now, load;
    logic [6:0] ld_min;
    logic [5:0] ld_sec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            down_q <= 1'b0;
        end else if (state == IDLE) begin
            down_q <= mode_down;
        end
    end

    assign expire_now = down_q && time_zero;
    assign load       = (state == IDLE) && (state_next == RUN) && mode_down;
    assign ld_min     = (preset_min > MIN_TOP) ? MIN_TOP : preset_min;
    assign ld_sec     = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
    assign expired    = (state == EXPIRED);
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode_down, preset_min, preset_sec};
    assign down_q     = 1'b0;
    assign expired    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pulse_ss) state_next = RUN;
            RUN: begin
                if (pulse_ss)        state_next = STOP;
                else if (sat)        state_next = STOP;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
                else if (expire_now) state_next = EXPIRED;
`endif
                else if (pulse_lap)  state_next = LAP;
            end
            LAP: begin
                if (pulse_ss)        state_next = STOP;
                else if (sat)        state_next = STOP;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
                else if (expire_now) state_next = EXPIRED;
`endif
            end
            STOP: begin
                if (pulse_ss)       state_next = RUN;
                else if (pulse_lap) state_next = IDLE;
            end
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
            EXPIRED: if (pulse_ss || pulse_lap) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
        if (pulse_clr) state_next = IDLE;
    end

    always_comb begin
        inc_min  = min_q;
        inc_sec  = sec_q;
        inc_frac = frac_q + 1'b1;
        if (frac_q == FRAC_TOP) begin
            inc_frac = '0;
            if (sec_q == 6'd59) begin
                inc_sec = 6'd0;
                inc_min = min_q + 7'd1;
            end else begin
                inc_sec = sec_q + 6'd1;
            end
        end
    end

    always_comb begin
        dec_min  = min_q;
        dec_sec  = sec_q;
        dec_frac = frac_q - 1'b1;
        if (frac_q == '0) begin
            dec_frac = FRAC_TOP;
            if (sec_q == 6'd0) begin
                dec_sec = 6'd59;
                dec_min = min_q - 7'd1;
            end else begin
                dec_sec = sec_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc      <= '0;
            min_q      <= 7'd0;
            sec_q      <= 6'd0;
            frac_q     <= '0;
            lap_min_q  <= 7'd0;
            lap_sec_q  <= 6'd0;
            lap_frac_q <= '0;
            ovf_q      <= 1'b0;
        end else if (state_next == IDLE) begin
            presc      <= '0;
            min_q      <= 7'd0;
            sec_q      <= 6'd0;
            frac_q     <= '0;
            lap_min_q  <= 7'd0;
            lap_sec_q  <= 6'd0;
            lap_frac_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (counting) presc <= tick ? '0 : presc + 1'b1;

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
            if (load) begin
                min_q  <= ld_min;
                sec_q  <= ld_sec;
                frac_q <= '0;
            end else
`endif
            if (tick) begin
                if (down_q) begin
                    if (!time_zero) begin
                        min_q  <= dec_min;
                        sec_q  <= dec_sec;
                        frac_q <= dec_frac;
                    end
                end else if (!at_max) begin
                    min_q  <= inc_min;
                    sec_q  <= inc_sec;
                    frac_q <= inc_frac;
                end
            end

            // Registers still hold the pre-tick value here, so a coincident tick is not captured.
            if (pulse_lap && state_next == LAP) begin
                lap_min_q  <= min_q;
                lap_sec_q  <= sec_q;
                lap_frac_q <= frac_q;
            end

            if (sat) ovf_q <= 1'b1;
        end
    end

    assign running    = counting;
    assign lap_active = (state == LAP);
    assign overflow   = ovf_q;
    assign minutes    = lap_active ? lap_min_q  : min_q;
    assign seconds    = lap_active ? lap_sec_q  : sec_q;
    assign fraction   = lap_active ? lap_frac_q : frac_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomised bench for lap_stopwatch: a cycle-count model derives the displayed time arithmetically.
module tb_lap_stopwatch;

    localparam int CLK_HZ      = 300;
    localparam int TICK_HZ     = 100;
    localparam int MAX_MINUTES = 1;
    localparam int SYNC_STAGES = 2;
    localparam int DIV         = CLK_HZ / TICK_HZ;
    localparam int MAXH        = MAX_MINUTES * 6000 + 5999;
    localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_STOP = 3, S_EXP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start_stop, btn_lap, btn_clear, mode_down;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [6:0] fraction;
    logic       running, lap_active, overflow, expired;

    logic [23:0] obs, exp_v;
    int errors = 0;
    int checks = 0;

    // model: cycles spent counting, latched split and countdown load, all in hundredths
    int   m_state, m_cycles, m_lap, m_load;
    logic m_ovf, m_down;

    lap_stopwatch #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MINUTES(MAX_MINUTES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .mode_down(mode_down), .preset_min(preset_min), .preset_sec(preset_sec),
        .minutes(minutes), .seconds(seconds), .fraction(fraction),
        .running(running), .lap_active(lap_active), .overflow(overflow), .expired(expired)
    );

    always #5 clk = ~clk;

    assign obs = {minutes, seconds, fraction, running, lap_active, overflow, expired};

    function automatic int time_h(input int c);
        int t;
        if (m_down) begin
            t = m_load - c / DIV;
            if (t < 0) t = 0;
        end else begin
            t = c / DIV;
            if (t > MAXH) t = MAXH;
        end
        return t;
    endfunction

    function automatic logic [23:0] exp_bus();
        int h;
        h = (m_state == S_LAP) ? m_lap : time_h(m_cycles);
        return {7'(h / 6000), 6'((h / 100) % 60), 7'(h % 100),
                (m_state == S_RUN || m_state == S_LAP), (m_state == S_LAP), m_ovf, (m_state == S_EXP)};
    endfunction

    function automatic void model_idle();
        m_state = S_IDLE; m_cycles = 0; m_lap = 0; m_ovf = 1'b0; m_down = 1'b0; m_load = 0;
    endfunction

    function automatic void model_edge();
        if (m_state == S_RUN || m_state == S_LAP) begin
            if (m_down) begin
                if (time_h(m_cycles) == 0) m_state = S_EXP;
                else m_cycles++;
            end else begin
                m_cycles++;
                if (m_cycles / DIV > MAXH) begin
                    m_cycles = MAXH * DIV;
                    m_ovf    = 1'b1;
                    m_state  = S_STOP;
                end
            end
        end
    endfunction

    function automatic void model_button(input logic ss, input logic lp, input logic cl);
        if (cl) begin
            model_idle();
        end else begin
            case (m_state)
                S_IDLE: if (ss) begin
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
                    m_down = mode_down;
                    m_load = ((preset_min > 7'(MAX_MINUTES)) ? MAX_MINUTES : int'(preset_min)) * 6000
                           + ((preset_sec > 6'd59) ? 59 : int'(preset_sec)) * 100;
`endif
                    m_state = S_RUN;
                end
                S_RUN: begin
                    if (ss) m_state = S_STOP;
                    else if (lp) begin m_lap = time_h(m_cycles - 1); m_state = S_LAP; end
                end
                S_LAP: begin
                    if (ss) m_state = S_STOP;
                    else if (lp) m_lap = time_h(m_cycles - 1);
                end
                S_STOP: begin
                    if (ss) m_state = S_RUN;
                    else if (lp) model_idle();
                end
                S_EXP: if (ss || lp) model_idle();
                default: model_idle();
            endcase
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
        #1;
    endtask

    // Pulse reaches the FSM SYNC_STAGES+1 edges after the raw rise; then let the synchroniser drain.
    task automatic press(input logic ss, input logic lp, input logic cl);
        @(negedge clk);
        btn_start_stop = ss; btn_lap = lp; btn_clear = cl;
        repeat (SYNC_STAGES + 1) step();
        #1;
        model_button(ss, lp, cl);
        btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
        repeat (SYNC_STAGES + 1) step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        model_idle();
        wait_cycles(3);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        @(negedge clk) reset = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        wait_cycles($urandom_range(100, 400));
        #2 reset = 1'b0;
        model_idle();
        #1;
        checks++;
        if (obs !== 24'h0) begin errors++; $display("FAIL reset_async: got %h want 000000", obs); end
        @(negedge clk) reset = 1'b1;
        wait_cycles(500);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_quiet: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_run_pause();
        press(1'b1, 1'b0, 1'b0);
        wait_cycles(DIV * 100 - (SYNC_STAGES + 1));
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL run_one_second: got %h want %h", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            wait_cycles($urandom_range(20, 900));
            exp_v = exp_bus();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL run_live: got %h want %h", obs, exp_v); end
            press(1'b1, 1'b0, 1'b0);
            wait_cycles($urandom_range(100, 300));
            exp_v = exp_bus();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL pause_hold: got %h want %h", obs, exp_v); end
            press(1'b1, 1'b0, 1'b0);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stop_lap_idle: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_lap();
        int k;
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0, 1'b0);
            wait_cycles($urandom_range(40, 400));
            // first pass lands the lap pulse on a tick edge, second pass just off it
            if (i < 2) begin
                k = 0;
                while (((m_cycles + k + SYNC_STAGES + 1) % DIV) != ((i == 0) ? 0 : 1)) k++;
                wait_cycles(k);
            end
            press(1'b0, 1'b1, 1'b0);
            exp_v = exp_bus();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lap_capture: got %h want %h", obs, exp_v); end
            wait_cycles($urandom_range(30, 300));
            exp_v = exp_bus();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lap_frozen: got %h want %h", obs, exp_v); end
            press(1'b0, 1'b1, 1'b0);
            exp_v = exp_bus();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lap_relatch: got %h want %h", obs, exp_v); end
            press(1'b1, 1'b0, 1'b0);
            exp_v = exp_bus();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lap_to_stop_live: got %h want %h", obs, exp_v); end
            press(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_priority();
        press(1'b1, 1'b0, 1'b0);
        wait_cycles($urandom_range(50, 300));
        press(1'b1, 1'b0, 1'b1);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clear_beats_start: got %h want %h", obs, exp_v); end
        press(1'b1, 1'b0, 1'b0);
        wait_cycles($urandom_range(50, 300));
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clear_beats_lap: got %h want %h", obs, exp_v); end
        press(1'b1, 1'b0, 1'b0);
        wait_cycles($urandom_range(50, 300));
        press(1'b1, 1'b1, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL start_beats_lap: got %h want %h", obs, exp_v); end
        press(1'b0, 1'b0, 1'b1);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clear_from_stop: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_overflow();
        int guard;
        press(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_state != S_STOP && guard < 50000) begin
            step();
            guard++;
        end
        #1;
        checks++;
        if (guard >= 50000) begin errors++; $display("FAIL overflow_timeout: got no saturation want stop"); end
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overflow_sat: got %h want %h", obs, exp_v); end
        wait_cycles($urandom_range(20, 100));
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overflow_hold: got %h want %h", obs, exp_v); end
        press(1'b1, 1'b0, 1'b0);
        wait_cycles(DIV);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overflow_resume: got %h want %h", obs, exp_v); end
        press(1'b0, 1'b1, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overflow_cleared: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_countdown();
        int guard;
        mode_down  = 1'b1;
        preset_min = 7'd0;
        preset_sec = 6'd2;
        press(1'b1, 1'b0, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_start: got %h want %h", obs, exp_v); end
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
        wait_cycles($urandom_range(50, 400));
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_counting: got %h want %h", obs, exp_v); end
        guard = 0;
        while (m_state != S_EXP && guard < 2000) begin
            step();
            guard++;
        end
        #1;
        checks++;
        if (guard >= 2000) begin errors++; $display("FAIL cd_timeout: got no expiry want expired"); end
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_expired: got %h want %h", obs, exp_v); end
        press(1'b0, 1'b1, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_exit: got %h want %h", obs, exp_v); end
        preset_sec = 6'd0;
        press(1'b1, 1'b0, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_zero_preset: got %h want %h", obs, exp_v); end
        press(1'b1, 1'b0, 1'b0);
        preset_min = 7'd100;
        preset_sec = 6'd63;
        press(1'b1, 1'b0, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_clamp: got %h want %h", obs, exp_v); end
        wait_cycles($urandom_range(20, 200));
        press(1'b0, 1'b1, 1'b0);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_lap: got %h want %h", obs, exp_v); end
        press(1'b0, 1'b0, 1'b1);
`else
        guard = $urandom_range(300, 700);
        wait_cycles(guard);
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mode_ignored: got %h want %h", obs, exp_v); end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
`endif
        mode_down  = 1'b0;
        preset_min = 7'd0;
        preset_sec = 6'd0;
        exp_v = exp_bus();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cd_back_idle: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        mode_down      = 1'b0;
        preset_min     = 7'd0;
        preset_sec     = 6'd0;
        model_idle();
        test_reset();
        test_run_pause();
        test_lap();
        test_priority();
        test_overflow();
        test_countdown();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
